// File: rtl/sar_search_pkg.sv
// Shared definitions for the sequential ALU blocks: FSM state encodings and default operand width.
package sar_search_pkg;

    localparam int SAR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TEST = 2'd1,
        ST_DONE = 2'd2
    } sar_state_t;

endpackage

// File: rtl/gt_cmp.sv
// Unsigned greater-than comparator: gt = (a > b). Purely combinational.
module gt_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt
);

    assign gt = (a > b);

endmodule

// File: rtl/sar_mask.sv
// Low-bit mask generator: mask = 2^k - 1, i.e. every bit strictly below bit k set.
module sar_mask #(
    parameter int WIDTH = 8,
    parameter int KW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] mask
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign mask = (ONE << k) - ONE;

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search of an unsigned target using an external greater-than comparator.
// guess is registered: each edge loads the guess for the bit tested in the following cycle.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gt,
    output logic [WIDTH-1:0] guess,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int            KW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_TOP  = KW'(WIDTH - 1);
    localparam logic [KW-1:0] K_ONE  = {{(KW-1){1'b0}}, 1'b1};

    sar_state_t       state_r;
    logic [KW-1:0]    k_r;
    logic [KW-1:0]    k_nxt_s;
    logic [WIDTH-1:0] res_upd_s;
    logic [WIDTH-1:0] mask_s;

    // Result with the bit under test resolved, and the bit index tested next cycle.
    always_comb begin
        res_upd_s      = result;
        res_upd_s[k_r] = gt;
        if (state_r == ST_TEST) begin
            k_nxt_s = k_r - K_ONE;
        end else begin
            k_nxt_s = K_TOP;
        end
    end

    sar_mask #(.WIDTH(WIDTH), .KW(KW)) u_mask (
        .k    (k_nxt_s),
        .mask (mask_s)
    );

    // FSM and datapath; bits below the next k are still zero, so OR-ing the mask forms the guess.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            k_r     <= K_TOP;
            result  <= '0;
            guess   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= ST_TEST;
                        k_r     <= K_TOP;
                        result  <= '0;
                        guess   <= mask_s;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        guess   <= '0;
                        busy    <= 1'b0;
                    end
                end
                ST_TEST: begin
                    result <= res_upd_s;
                    if (k_r == '0) begin
                        state_r <= ST_DONE;
                        k_r     <= K_TOP;
                        guess   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        k_r     <= k_nxt_s;
                        guess   <= res_upd_s | mask_s;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    k_r     <= K_TOP;
                    guess   <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed cases plus a shuffled sweep of all targets,
// checked against an arithmetic model of the MSB-first search.
module tb_sar_search;

    logic       clk;
    logic       rst;
    logic       start;
    logic       gt;
    logic [7:0] target;
    logic [7:0] guess;
    logic [7:0] result;
    logic       busy;
    logic       done;

    int checks;
    int failures;

    sar_search dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .gt     (gt),
        .guess  (guess),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    gt_cmp #(.WIDTH(8)) u_cmp (
        .a  (target),
        .b  (guess),
        .gt (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after the start-accept edge; walks the 8 TEST cycles and checks the DONE cycle.
    task automatic run_body(input logic [7:0] tgt, input bit rnd_start);
        logic [7:0] res;
        logic [7:0] bitv;
        logic [7:0] g;
        res = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bitv = 8'h01 << i;
            g    = res | (bitv - 8'h01);
            check_val("guess", guess, g);
            check_val("gt", gt, (tgt > g));
            check_val("busy_test", busy, 1);
            check_val("done_test", done, 0);
            if (tgt >= (res | bitv))
                res = res | bitv;
            if (rnd_start)
                start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check_val("done_pulse", done, 1);
        check_val("busy_done", busy, 0);
        check_val("guess_done", guess, 0);
        check_val("result", result, tgt);
    endtask

    task automatic check_idle(input logic [7:0] held);
        check_val("idle_busy", busy, 0);
        check_val("idle_done", done, 0);
        check_val("idle_guess", guess, 0);
        check_val("idle_result", result, held);
    endtask

    task automatic do_search(input logic [7:0] tgt);
        target = tgt;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        run_body(tgt, 1'b0);
        @(posedge clk); #1;
        check_idle(tgt);
    endtask

    logic [7:0] perm [256];
    logic [7:0] tmp;
    logic [7:0] prev;
    int         j;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        target   = 8'h00;
        #12;
        check_val("rst_guess", guess, 0);
        check_val("rst_result", result, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_search(8'h00);
        do_search(8'hFF);
        do_search(8'hA5);

        // start held high: back-to-back searches, done every 9 cycles
        target = 8'h3C;
        start  = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 3; n++) begin
            run_body(8'h3C, 1'b0);
            if (n < 2) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        check_idle(8'h3C);

        // asynchronous reset while testing bit 3
        target = 8'h5A;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_val("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_val("async_guess", guess, 0);
        check_val("async_result", result, 0);
        check_val("async_busy", busy, 0);
        check_val("async_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_search(8'h81);

        // shuffled sweep of every target with random idle gaps and start noise during TEST
        for (int i = 0; i < 256; i++)
            perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j       = $urandom_range(0, i);
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        prev = 8'h81;
        for (int i = 0; i < 256; i++) begin
            target = 8'($urandom);
            start  = 1'b0;
            check_idle(prev);
            target = perm[i];
            start  = 1'b1;
            @(posedge clk); #1;
            run_body(perm[i], 1'b1);
            start = 1'b0;
            prev  = perm[i];
            repeat ($urandom_range(1, 3)) begin
                target = 8'($urandom);
                @(posedge clk); #1;
                check_idle(prev);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
